// File: rtl/wram_pkg.sv
// wram_pkg: shared constants and enums for the WRAM arbiter slice
package wram_pkg;
  localparam logic [15:0] WRAM_CPU_BASE = 16'h6000;
  localparam logic [21:0] WRAM_RV_BASE  = 22'h66000;
  localparam int          WRAM_SIZE     = 8192;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} rv_state_e;
  typedef enum logic [1:0] {G_NONE, G_CPU, G_CPU_BUF, G_RV} grant_e;
endpackage

// File: rtl/wram_bsram_8k.sv
// wram_bsram_8k: single-port 8-bit x 8192 block RAM, read-first, 1-cycle registered read
// Ports: clk; en_i enables the access; we_i writes din_i at addr_i;
//        dout_o holds the byte at addr_i as it was before the write.
module wram_bsram_8k
  import wram_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o
);
`ifdef FORMAL
  logic [7:0] mem [WRAM_SIZE];
`else
  (* ram_style = "block" *) logic [7:0] mem [WRAM_SIZE];
`endif
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem[addr_i] <= din_i;
      dout_o <= mem[addr_i];
    end
  end
endmodule

// File: rtl/wram_arbiter.sv
// wram_arbiter: one-byte-per-cycle arbiter between NES CPU and RISC-V for the 8 KB WRAM
// Ports: CPU side cpu_addr/cpu_we/cpu_oe/cpu_din -> cpu_dout/cpu_rvalid, cpu_hit;
//        RV side rv_addr/rv_din/rv_ds/rv_we + toggle rv_req -> rv_req_ack/rv_dout, rv_hit;
//        i_wram_load_ongoing gives RV priority and parks CPU strobes in a 1-entry buffer.
module wram_arbiter
  import wram_pkg::*;
#(
  parameter int RV_MAX_WAIT = 4,
  parameter int WRAM_AW     = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic        cpu_oe,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_rvalid,
  output logic        cpu_hit,
  input  logic [21:0] rv_addr,
  input  logic [15:0] rv_din,
  input  logic [1:0]  rv_ds,
  input  logic        rv_we,
  input  logic        rv_req,
  output logic        rv_req_ack,
  output logic [15:0] rv_dout,
  output logic        rv_hit,
  input  logic        i_wram_load_ongoing
);
  localparam int WW = $clog2(RV_MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(RV_MAX_WAIT);
  rv_state_e st_q, st_d;
  grant_e g;
  logic [WW-1:0] wait_q, wait_d;
  logic buf_v_q, buf_we_q;
  logic [WRAM_AW-1:0] buf_addr_q;
  logic [7:0] buf_din_q;
  logic [WRAM_AW-2:0] ra_q;
  logic [15:0] rd_q;
  logic [1:0] rds_q, rv_rd_q;
  logic rwe_q, cpu_rd_q;
  logic cpu_strobe, rv_pend, rv_lane, rv_first;
  logic ram_we;
  logic [WRAM_AW-1:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic unused_rv_lsb;
  assign unused_rv_lsb = rv_addr[0];
  assign cpu_hit = cpu_addr[15:WRAM_AW] == WRAM_CPU_BASE[15:WRAM_AW];
  assign rv_hit = rv_addr[21:WRAM_AW] == WRAM_RV_BASE[21:WRAM_AW];
  assign cpu_strobe = (cpu_we | cpu_oe) & cpu_hit;
  assign rv_pend = (rv_req != rv_req_ack) && rv_hit;
  assign rv_lane = st_q == LO || st_q == HI;
  assign rv_first = i_wram_load_ongoing || wait_q == WMAX;
  always_comb begin
    // a parked CPU access outranks new RV lanes, but not a starved or load-mode RV
    g = (rv_lane && rv_first) ? G_RV :
        (buf_v_q && !i_wram_load_ongoing) ? G_CPU_BUF :
        (cpu_strobe && !i_wram_load_ongoing) ? G_CPU :
        rv_lane ? G_RV : G_NONE;
    ram_addr = g == G_RV ? {ra_q, st_q == HI} : g == G_CPU_BUF ? buf_addr_q : cpu_addr[WRAM_AW-1:0];
    ram_we = g == G_RV ? rwe_q : g == G_CPU_BUF ? buf_we_q : g == G_CPU && cpu_we;
    ram_din = g == G_RV ? (st_q == HI ? rd_q[15:8] : rd_q[7:0]) : g == G_CPU_BUF ? buf_din_q : cpu_din;
    wait_d = (st_q == IDLE || g == G_RV) ? '0 : (rv_lane && wait_q != WMAX) ? wait_q + 1'b1 : wait_q;
    st_d = IDLE;
    case (st_q)
      IDLE: st_d = rv_pend ? (rv_ds[0] ? LO : rv_ds[1] ? HI : DONE) : IDLE;
      LO: st_d = g == G_RV ? (rds_q[1] ? HI : DONE) : LO;
      HI: st_d = g == G_RV ? DONE : HI;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      wait_q <= '0;
      buf_v_q <= 1'b0;
      buf_we_q <= 1'b0;
      buf_addr_q <= '0;
      buf_din_q <= '0;
      ra_q <= '0;
      rd_q <= '0;
      rds_q <= '0;
      rwe_q <= 1'b0;
      cpu_rd_q <= 1'b0;
      rv_rd_q <= '0;
      cpu_dout <= '0;
      cpu_rvalid <= 1'b0;
      rv_req_ack <= 1'b0;
      rv_dout <= '0;
    end else begin
      st_q <= st_d;
      wait_q <= wait_d;
      cpu_rd_q <= (g == G_CPU && !cpu_we) || (g == G_CPU_BUF && !buf_we_q);
      cpu_rvalid <= cpu_rd_q;
      if (cpu_rd_q) cpu_dout <= ram_dout;
      rv_rd_q <= {2{g == G_RV && !rwe_q}} & {st_q == HI, st_q == LO};
      if (st_q == IDLE && rv_pend) begin
        ra_q <= rv_addr[WRAM_AW-1:1];
        rd_q <= rv_din;
        rds_q <= rv_ds;
        rwe_q <= rv_we;
        if (!rv_we) rv_dout <= '0;
      end
      if (rv_rd_q[0]) rv_dout[7:0] <= ram_dout;
      if (rv_rd_q[1]) rv_dout[15:8] <= ram_dout;
      if (cpu_strobe && g != G_CPU) begin
        buf_v_q <= 1'b1;
        buf_we_q <= cpu_we;
        buf_addr_q <= cpu_addr[WRAM_AW-1:0];
        buf_din_q <= cpu_din;
      end else if (g == G_CPU_BUF) buf_v_q <= 1'b0;
      // the last read lane lands on this same edge, so ack and data appear together
      if (st_q == DONE) rv_req_ack <= ~rv_req_ack;
    end
  end
`ifdef FORMAL
  always_ff @(posedge clk) if (!reset) assert (!(cpu_strobe && buf_v_q && g != G_CPU_BUF && g != G_CPU));
`endif
  // reset gating drops an in-flight RV lane instead of finishing it
  wram_bsram_8k #(.AW(WRAM_AW)) u_ram (
    .clk(clk),
    .en_i(g != G_NONE && !reset),
    .we_i(ram_we),
    .addr_i(ram_addr),
    .din_i(ram_din),
    .dout_o(ram_dout)
  );
endmodule

// File: tb/tb_wram_arbiter.sv
// tb_wram_arbiter: scoreboard bench for wram_arbiter
module tb_wram_arbiter;
  logic clk = 1'b0;
  logic reset, cpu_we, cpu_oe, cpu_rvalid, cpu_hit, rv_ds_we, rv_we, rv_req, rv_req_ack, rv_hit, load;
  logic [15:0] cpu_addr, rv_din, rv_dout;
  logic [7:0] cpu_din, cpu_dout;
  logic [21:0] rv_addr;
  logic [1:0] rv_ds;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct { logic [7:0] data; int cyc; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [7:0] mem_m [8192];
  logic [15:0] rv_exp;
  int lat, base, ack_at;
  logic ack_before;
  wram_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_oe(cpu_oe), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_rvalid(cpu_rvalid), .cpu_hit(cpu_hit),
    .rv_addr(rv_addr), .rv_din(rv_din), .rv_ds(rv_ds), .rv_we(rv_we), .rv_req(rv_req),
    .rv_req_ack(rv_req_ack), .rv_dout(rv_dout), .rv_hit(rv_hit),
    .i_wram_load_ongoing(load)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cpu_idle();
    cpu_we = 1'b0;
    cpu_oe = 1'b0;
  endtask
  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_we = 1'b1;
    cpu_oe = 1'b0;
    cpu_din = d;
    if (a[15:13] == 3'b011) mem_m[a[12:0]] = d;
  endtask
  task automatic cpu_rd(input logic [15:0] a, input int l);
    cpu_addr = a;
    cpu_we = 1'b0;
    cpu_oe = 1'b1;
    if (a[15:13] == 3'b011) sb.push_back('{mem_m[a[12:0]], cyc + l});
  endtask
  task automatic rv_start(input logic [21:0] a, input logic [15:0] d, input logic [1:0] ds, input logic we);
    logic [12:0] lo, hi;
    lo = {a[12:1], 1'b0};
    hi = {a[12:1], 1'b1};
    rv_addr = a;
    rv_din = d;
    rv_ds = ds;
    rv_we = we;
    rv_exp = {ds[1] ? mem_m[hi] : 8'h00, ds[0] ? mem_m[lo] : 8'h00};
    if (we && ds[0]) mem_m[lo] = d[7:0];
    if (we && ds[1]) mem_m[hi] = d[15:8];
    rv_req = ~rv_req;
  endtask
  task automatic rv_txn(input logic [21:0] a, input logic [15:0] d, input logic [1:0] ds, input logic we, input int exp_lat);
    int t0;
    rv_start(a, d, ds, we);
    t0 = cyc;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rv_req_ack == rv_req) begin
        lat = cyc - t0;
        break;
      end
    end
    chk("rv_ack_latency", lat, exp_lat);
    if (!we) chk("rv_dout", rv_dout, rv_exp);
    tick();
  endtask
  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (sb.size() == 0) chk("cpu_rvalid_spurious", cpu_rvalid, 1'b0);
      else begin
        e = sb.pop_front();
        chk("cpu_dout", cpu_dout, e.data);
        chk("cpu_rvalid_cycle", cyc, e.cyc);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1; load = 1'b0; rv_ds_we = 1'b0;
    cpu_addr = '0; cpu_we = 1'b0; cpu_oe = 1'b0; cpu_din = '0;
    rv_addr = '0; rv_din = '0; rv_ds = '0; rv_we = 1'b0; rv_req = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_rv_req_ack", rv_req_ack, 0);
    chk("rst_rv_dout", rv_dout, 0);
    tick();
    reset = 1'b0;
    cpu_addr = 16'h7FFF; #1 chk("cpu_hit_7fff", cpu_hit, 1);
    cpu_addr = 16'h8000; #1 chk("cpu_hit_8000", cpu_hit, 0);
    cpu_addr = 16'h5FFF; #1 chk("cpu_hit_5fff", cpu_hit, 0);
    rv_addr = 22'h67FFF; #1 chk("rv_hit_67fff", rv_hit, 1);
    rv_addr = 22'h68000; #1 chk("rv_hit_68000", rv_hit, 0);
    rv_addr = 22'h65FFF; #1 chk("rv_hit_65fff", rv_hit, 0);
    tick();
    cpu_wr(16'h6005, 8'hA5); tick();
    cpu_rd(16'h6005, 2); tick();
    cpu_wr(16'h7FFF, 8'h99); tick();
    cpu_wr(16'h5FFF, 8'hEE); tick();
    cpu_wr(16'h8000, 8'hEE); tick();
    cpu_rd(16'h8000, 2); #1 chk("cpu_hit_oow_strobe", cpu_hit, 0); tick();
    cpu_rd(16'h7FFF, 2); tick();
    cpu_wr(16'h6070, 8'h3C); cpu_oe = 1'b1; tick();
    cpu_rd(16'h6070, 2); tick();
    cpu_idle();
    repeat (4) tick();
    rv_txn(22'h66010, 16'h1234, 2'b11, 1'b1, 4);
    rv_txn(22'h66011, 16'h0000, 2'b11, 1'b0, 4);
    cpu_rd(16'h6010, 2); tick();
    cpu_rd(16'h6011, 2); tick();
    cpu_wr(16'h6020, 8'h11); tick();
    cpu_wr(16'h6021, 8'h22); tick();
    cpu_idle();
    repeat (3) tick();
    rv_txn(22'h66020, 16'h0000, 2'b10, 1'b0, 3);
    rv_txn(22'h66020, 16'h0000, 2'b00, 1'b0, 2);
    ack_before = rv_req_ack;
    rv_addr = 22'h68000; rv_ds = 2'b11; rv_we = 1'b1; rv_req = ~rv_req;
    repeat (6) tick();
    chk("rv_oow_no_ack", rv_req_ack, ack_before);
    rv_req = rv_req_ack;
    tick();
    for (int i = 0; i < 10; i++) begin
      cpu_wr(16'(16'h6040 + i), 8'(8'h40 + i));
      tick();
    end
    cpu_wr(16'h6030, 8'h5A); tick();
    cpu_idle(); tick();
    rv_start(22'h66030, 16'h0000, 2'b01, 1'b0);
    base = cyc;
    ack_at = -1;
    for (int i = 0; i < 16; i++) begin
      if (i < 10) cpu_rd(16'(16'h6040 + i), i < 5 ? 2 : 3);
      else cpu_idle();
      @(negedge clk);
      if (ack_at < 0 && rv_req_ack == rv_req) ack_at = cyc - base;
      tick();
    end
    chk("starve_rv_ack_cycle", ack_at, 7);
    chk("starve_rv_dout", rv_dout, rv_exp);
    load = 1'b1;
    rv_start(22'h66060, 16'hCAFE, 2'b11, 1'b1);
    base = cyc;
    ack_at = -1;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) cpu_wr(16'h6000, 8'h77);
      else if (i == 6) begin
        load = 1'b0;
        cpu_rd(16'h6000, 3);
      end else cpu_idle();
      @(negedge clk);
      if (ack_at < 0 && rv_req_ack == rv_req) ack_at = cyc - base;
      tick();
    end
    chk("load_rv_ack_cycle", ack_at, 4);
    cpu_rd(16'h6060, 2); tick();
    cpu_rd(16'h6061, 2); tick();
    cpu_idle();
    repeat (3) tick();
    rv_txn(22'h66060, 16'h0000, 2'b11, 1'b0, 4);
    rv_addr = 22'h66050; rv_din = 16'hBEEF; rv_ds = 2'b11; rv_we = 1'b1; rv_req = ~rv_req;
    mem_m[13'h0050] = 8'hEF;
    tick();
    tick();
    cpu_addr = 16'h6052; cpu_oe = 1'b1; tick();
    cpu_idle();
    reset = 1'b1;
    rv_req = 1'b0;
    @(negedge clk);
    chk("pre_reset_ack", rv_req_ack, 1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_hi_ack", rv_req_ack, 0);
    chk("reset_hi_rvalid", cpu_rvalid, 0);
    chk("reset_hi_rv_dout", rv_dout, 0);
    repeat (3) tick();
    chk("reset_no_restart", rv_req_ack, 0);
    cpu_rd(16'h6050, 2); tick();
    cpu_idle();
    repeat (5) tick();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
